// File: rtl/tcdm_bank_pkg.sv
// ---------------------------------------------------------------------------
// tcdm_bank_pkg
// Shared definitions for the TCDM bank responder.
//   ByteWidth    : width of one byte lane (8)
//   resp_width() : packed width of one response-pipeline stage
//                  ({vld, rd, data}) for a given data width
//   be_merge()   : per-lane store merge (byte enable selects new or old byte)
// The response stage struct itself depends on DataWidth, so it is declared
// inside tcdm_bank_responder where that parameter is known.
// ---------------------------------------------------------------------------
package tcdm_bank_pkg;

    localparam int unsigned ByteWidth = 8;

    // Two flag bits (vld, rd) followed by the data word.
    function automatic int unsigned resp_width(input int unsigned data_width);
        return data_width + 2;
    endfunction

    // One byte lane of a partial store: keep the old byte unless enabled.
    function automatic logic [ByteWidth-1:0] be_merge(
        input logic [ByteWidth-1:0] old_val,
        input logic [ByteWidth-1:0] new_val,
        input logic                 be
    );
        return be ? new_val : old_val;
    endfunction

endpackage

// File: rtl/tcdm_lat_pipe.sv
// ---------------------------------------------------------------------------
// tcdm_lat_pipe
// Generic Depth-stage shift register with asynchronous active-low reset.
// Used to delay responses of the bank by a fixed number of cycles.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears every stage to zero
//   data_i  : value entering stage 1 at each rising edge
//   data_o  : value of the last stage (data_i delayed by Depth cycles)
// ---------------------------------------------------------------------------
module tcdm_lat_pipe #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] stage_q [Depth];

    genvar gi;
    for (gi = 0; gi < Depth; gi++) begin : g_stage
        logic [Width-1:0] stage_d;

        if (gi == 0) begin : g_first
            assign stage_d = data_i;
        end else begin : g_shift
            assign stage_d = stage_q[gi-1];
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stage_q[gi] <= '0;
            end else begin
                stage_q[gi] <= stage_d;
            end
        end
    end

    assign data_o = stage_q[Depth-1];

endmodule

// File: rtl/tcdm_bank_responder.sv
// ---------------------------------------------------------------------------
// tcdm_bank_responder
// Bank-side endpoint of the TCDM request network. Accepts at most one request
// per granted cycle, performs it on a local word-addressed memory and returns
// a response exactly MemLatency cycles after the accept.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (clears memory, pipeline, throttle)
//   req_i    : request valid, held by the initiator until granted
//   add_i    : word address
//   wen_i    : 1 = store, 0 = load
//   be_i     : byte enables for stores
//   wdata_i  : store data
//   stall_i  : external grant inhibit
//   gnt_o    : grant (combinational on req_i, stall_i and throttle counter)
//   vld_o    : response valid, one cycle per response
//   rdata_o  : load data on a load response, zero otherwise
// ---------------------------------------------------------------------------
module tcdm_bank_responder
    import tcdm_bank_pkg::*;
#(
    parameter int unsigned NumWords    = 256,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned MemLatency  = 1,
    parameter bit          WriteRespOn = 1'b1,
    parameter int unsigned GntPeriod   = 1,
    localparam int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth    = DataWidth / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic [AddrWidth-1:0] add_i,
    input  logic                 wen_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 stall_i,
    output logic                 gnt_o,
    output logic                 vld_o,
    output logic [DataWidth-1:0] rdata_o
);

    typedef struct packed {
        logic                 vld;
        logic                 rd;
        logic [DataWidth-1:0] data;
    } resp_stage_t;

    localparam int unsigned ThrWidth = (GntPeriod > 1) ? $clog2(GntPeriod) : 1;
    localparam logic [ThrWidth-1:0] ThrReload = ThrWidth'(GntPeriod - 1);
    localparam int unsigned RespWidth = resp_width(DataWidth);

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [ThrWidth-1:0]  thr_cnt_q, thr_cnt_d;

    logic                 accept;
    logic                 rd_accept;
    logic                 wr_accept;
    logic [DataWidth-1:0] rd_word;
    logic [DataWidth-1:0] wr_word;
    resp_stage_t          resp_in;
    resp_stage_t          resp_out;

    // ------------------------------------------------------------------
    // Grant and accept. The reset term keeps gnt_o low while the bank is
    // held in reset even if an initiator is already requesting.
    // ------------------------------------------------------------------
    assign gnt_o     = rst_ni & req_i & ~stall_i & (thr_cnt_q == '0);
    assign accept    = req_i & gnt_o;
    assign rd_accept = accept & ~wen_i;
    assign wr_accept = accept &  wen_i;

    // ------------------------------------------------------------------
    // Throttle counter: reloads on accept, otherwise counts down to zero.
    // stall_i has no effect here so a stall never stretches the period.
    // ------------------------------------------------------------------
    always_comb begin
        thr_cnt_d = thr_cnt_q;
        if (accept) begin
            thr_cnt_d = ThrReload;
        end else if (thr_cnt_q != '0) begin
            thr_cnt_d = thr_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thr_cnt_q <= '0;
        end else begin
            thr_cnt_q <= thr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory. Only one access is accepted per cycle, so a load never
    // collides with a store; a load in the cycle after a store reads the
    // already-updated word.
    // ------------------------------------------------------------------
    assign rd_word = mem_q[add_i];

    genvar gi;
    for (gi = 0; gi < BeWidth; gi++) begin : g_be_lane
        assign wr_word[gi*ByteWidth +: ByteWidth] =
            be_merge(rd_word[gi*ByteWidth +: ByteWidth],
                     wdata_i[gi*ByteWidth +: ByteWidth],
                     be_i[gi]);
    end

    // The whole array is cleared on reset, so it maps to flops rather
    // than a RAM macro.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_accept) begin
            mem_q[add_i] <= wr_word;
        end
    end

    // ------------------------------------------------------------------
    // Response path. Stage 1 captures the read word at the accept edge;
    // with MemLatency = 1 that register drives the outputs directly.
    // ------------------------------------------------------------------
    always_comb begin
        resp_in      = '0;
        resp_in.vld  = rd_accept | (wr_accept & WriteRespOn);
        resp_in.rd   = rd_accept;
        resp_in.data = rd_accept ? rd_word : '0;
    end

    tcdm_lat_pipe #(
        .Depth (MemLatency),
        .Width (RespWidth)
    ) i_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .data_i (resp_in),
        .data_o (resp_out)
    );

    assign vld_o   = resp_out.vld;
    // Store responses and idle cycles present zero data.
    assign rdata_o = (resp_out.vld & resp_out.rd) ? resp_out.data : '0;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
module tb_tcdm_bank_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req;
    logic [7:0]  add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall;

    logic gnt_a, vld_a, gnt_b, vld_b, gnt_c, vld_c, gnt_d, vld_d;
    logic [31:0] rdata_a, rdata_b, rdata_c, rdata_d;

    // A: defaults. B: latency 3, no write responses. C: latency 2, grant
    // period 3. D: latency 4. All share the same request inputs.
    tcdm_bank_responder #(.NumWords(256), .DataWidth(32), .MemLatency(1),
        .WriteRespOn(1'b1), .GntPeriod(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .be_i(be), .wdata_i(wdata), .stall_i(stall),
        .gnt_o(gnt_a), .vld_o(vld_a), .rdata_o(rdata_a));

    tcdm_bank_responder #(.NumWords(256), .DataWidth(32), .MemLatency(3),
        .WriteRespOn(1'b0), .GntPeriod(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .be_i(be), .wdata_i(wdata), .stall_i(stall),
        .gnt_o(gnt_b), .vld_o(vld_b), .rdata_o(rdata_b));

    tcdm_bank_responder #(.NumWords(256), .DataWidth(32), .MemLatency(2),
        .WriteRespOn(1'b1), .GntPeriod(3)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .be_i(be), .wdata_i(wdata), .stall_i(stall),
        .gnt_o(gnt_c), .vld_o(vld_c), .rdata_o(rdata_c));

    tcdm_bank_responder #(.NumWords(256), .DataWidth(32), .MemLatency(4),
        .WriteRespOn(1'b1), .GntPeriod(1)) dut_d (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen),
        .be_i(be), .wdata_i(wdata), .stall_i(stall),
        .gnt_o(gnt_d), .vld_o(vld_d), .rdata_o(rdata_d));

    typedef struct {
        bit          rq;
        bit          we;
        logic [7:0]  a;
        logic [3:0]  b;
        logic [31:0] wd;
        bit          stl;
        logic [31:0] ex;
        bit          g;
    } step_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   sel   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic get_gnt();
        case (sel)
            0: return gnt_a;
            1: return gnt_b;
            2: return gnt_c;
            default: return gnt_d;
        endcase
    endfunction

    function automatic logic get_vld();
        case (sel)
            0: return vld_a;
            1: return vld_b;
            2: return vld_c;
            default: return vld_d;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata();
        case (sel)
            0: return rdata_a;
            1: return rdata_b;
            2: return rdata_c;
            default: return rdata_d;
        endcase
    endfunction

    function automatic int lat_of();
        case (sel)
            0: return 1;
            1: return 3;
            2: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit wr_on();
        return (sel != 1);
    endfunction

    function automatic step_t mk(bit rq_v, bit we_v, logic [7:0] a_v,
                                 logic [3:0] b_v, logic [31:0] wd_v,
                                 bit stl_v, logic [31:0] ex_v, bit g_v);
        step_t s;
        s.rq = rq_v; s.we = we_v; s.a = a_v; s.b = b_v;
        s.wd = wd_v; s.stl = stl_v; s.ex = ex_v; s.g = g_v;
        return s;
    endfunction

    function automatic step_t idle();
        return mk(1'b0, 1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endfunction

    // Drives one cycle of stimulus and records the expected response.
    task automatic drive(input step_t s, output bit g);
        exp_t e;
        req = s.rq; wen = s.we; add = s.a; be = s.b; wdata = s.wd; stall = s.stl;
        #1;
        g = get_gnt();
        if (s.rq && g && (!s.we || wr_on())) begin
            e.due  = cyc + lat_of();
            e.data = s.we ? 32'h0 : s.ex;
            sb.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n);
        req = 1'b0; wen = 1'b0; add = '0; be = '0; wdata = '0; stall = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; wen = 1'b0; add = '0; be = '0; wdata = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt_a, vld_a, rdata_a} !== 34'h0) begin
            n_err++; $display("FAIL reset_a gnt=%b vld=%b rdata=%h expected all zero", gnt_a, vld_a, rdata_a);
        end
        n_cmp++;
        if ({gnt_b, vld_b, rdata_b} !== 34'h0) begin
            n_err++; $display("FAIL reset_b gnt=%b vld=%b rdata=%h expected all zero", gnt_b, vld_b, rdata_b);
        end
        n_cmp++;
        if ({gnt_c, vld_c, rdata_c} !== 34'h0) begin
            n_err++; $display("FAIL reset_c gnt=%b vld=%b rdata=%h expected all zero", gnt_c, vld_c, rdata_c);
        end
        n_cmp++;
        if ({gnt_d, vld_d, rdata_d} !== 34'h0) begin
            n_err++; $display("FAIL reset_d gnt=%b vld=%b rdata=%h expected all zero", gnt_d, vld_d, rdata_d);
        end
        rst_n = 1'b1; req = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({vld_a, vld_b, vld_c, vld_d} !== 4'h0) begin
            n_err++; $display("FAIL reset_release vld=%b expected 0000", {vld_a, vld_b, vld_c, vld_d});
        end
        $display("reset: checked outputs during and after reset");
    endtask

    task automatic test_write_read();
        step_t st[$]; exp_t e; bit g;
        sel = 0; idle_cycles(6); sb.delete();
        st.push_back(mk(1, 0, 8'h30, 4'h0, 32'h0,        0, 32'h0,        1));
        st.push_back(mk(1, 1, 8'h05, 4'hF, 32'hDEADBEEF, 0, 32'h0,        1));
        st.push_back(mk(1, 0, 8'h05, 4'h0, 32'h0,        0, 32'hDEADBEEF, 1));
        st.push_back(idle()); st.push_back(idle());
        foreach (st[k]) begin
            drive(st[k], g);
            n_cmp++;
            if (g !== st[k].g) begin
                n_err++; $display("FAIL wr_gnt step=%0d gnt=%b expected %b", k, g, st[k].g);
            end
            @(posedge clk); #1;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (get_vld() !== 1'b1 || get_rdata() !== e.data) begin
                    n_err++; $display("FAIL wr_resp cyc=%0d vld=%b rdata=%h expected vld=1 rdata=%h", cyc, get_vld(), get_rdata(), e.data);
                end else $display("wr_resp: cyc=%0d rdata=%h", cyc, get_rdata());
            end else begin
                n_cmp++;
                if (get_vld() !== 1'b0 || get_rdata() !== 32'h0) begin
                    n_err++; $display("FAIL wr_idle cyc=%0d vld=%b rdata=%h expected vld=0 rdata=0", cyc, get_vld(), get_rdata());
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL wr_missing pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_byte_enable();
        step_t st[$]; exp_t e; bit g;
        sel = 0; idle_cycles(6); sb.delete();
        st.push_back(mk(1, 1, 8'h07, 4'hF,    32'h11223344, 0, 32'h0,        1));
        st.push_back(mk(1, 1, 8'h07, 4'b0101, 32'hAABBCCDD, 0, 32'h0,        1));
        st.push_back(mk(1, 0, 8'h07, 4'h0,    32'h0,        0, 32'h11BB33DD, 1));
        st.push_back(mk(1, 1, 8'h07, 4'h0,    32'hFFFFFFFF, 0, 32'h0,        1));
        st.push_back(mk(1, 0, 8'h07, 4'h0,    32'h0,        0, 32'h11BB33DD, 1));
        st.push_back(idle()); st.push_back(idle());
        foreach (st[k]) begin
            drive(st[k], g);
            n_cmp++;
            if (g !== st[k].g) begin
                n_err++; $display("FAIL be_gnt step=%0d gnt=%b expected %b", k, g, st[k].g);
            end
            @(posedge clk); #1;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (get_vld() !== 1'b1 || get_rdata() !== e.data) begin
                    n_err++; $display("FAIL be_resp cyc=%0d vld=%b rdata=%h expected vld=1 rdata=%h", cyc, get_vld(), get_rdata(), e.data);
                end else $display("be_resp: cyc=%0d rdata=%h", cyc, get_rdata());
            end else begin
                n_cmp++;
                if (get_vld() !== 1'b0 || get_rdata() !== 32'h0) begin
                    n_err++; $display("FAIL be_idle cyc=%0d vld=%b rdata=%h expected vld=0 rdata=0", cyc, get_vld(), get_rdata());
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL be_missing pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        step_t st[$]; exp_t e; bit g;
        sel = 1; idle_cycles(6); sb.delete();
        for (int i = 0; i < 4; i++)
            st.push_back(mk(1, 1, 8'h10 + 8'(i), 4'hF, 32'hA0A00000 + 32'(i), 0, 32'h0, 1));
        for (int i = 0; i < 4; i++)
            st.push_back(mk(1, 0, 8'h10 + 8'(i), 4'h0, 32'h0, 0, 32'hA0A00000 + 32'(i), 1));
        for (int i = 0; i < 4; i++) st.push_back(idle());
        foreach (st[k]) begin
            drive(st[k], g);
            n_cmp++;
            if (g !== st[k].g) begin
                n_err++; $display("FAIL b2b_gnt step=%0d gnt=%b expected %b", k, g, st[k].g);
            end
            @(posedge clk); #1;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (get_vld() !== 1'b1 || get_rdata() !== e.data) begin
                    n_err++; $display("FAIL b2b_resp cyc=%0d vld=%b rdata=%h expected vld=1 rdata=%h", cyc, get_vld(), get_rdata(), e.data);
                end else $display("b2b_resp: cyc=%0d rdata=%h", cyc, get_rdata());
            end else begin
                n_cmp++;
                if (get_vld() !== 1'b0 || get_rdata() !== 32'h0) begin
                    n_err++; $display("FAIL b2b_idle cyc=%0d vld=%b rdata=%h expected vld=0 rdata=0", cyc, get_vld(), get_rdata());
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL b2b_missing pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_write_resp_off();
        step_t st[$]; exp_t e; bit g;
        sel = 1; idle_cycles(6); sb.delete();
        st.push_back(mk(1, 1, 8'h20, 4'hF, 32'hCAFE0001, 0, 32'h0,        1));
        st.push_back(mk(1, 0, 8'h20, 4'h0, 32'h0,        0, 32'hCAFE0001, 1));
        st.push_back(mk(1, 1, 8'h20, 4'hF, 32'hCAFE0002, 0, 32'h0,        1));
        for (int i = 0; i < 5; i++) st.push_back(idle());
        foreach (st[k]) begin
            drive(st[k], g);
            n_cmp++;
            if (g !== st[k].g) begin
                n_err++; $display("FAIL wroff_gnt step=%0d gnt=%b expected %b", k, g, st[k].g);
            end
            @(posedge clk); #1;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (get_vld() !== 1'b1 || get_rdata() !== e.data) begin
                    n_err++; $display("FAIL wroff_resp cyc=%0d vld=%b rdata=%h expected vld=1 rdata=%h", cyc, get_vld(), get_rdata(), e.data);
                end else $display("wroff_resp: cyc=%0d rdata=%h", cyc, get_rdata());
            end else begin
                n_cmp++;
                if (get_vld() !== 1'b0 || get_rdata() !== 32'h0) begin
                    n_err++; $display("FAIL wroff_idle cyc=%0d vld=%b rdata=%h expected vld=0 rdata=0", cyc, get_vld(), get_rdata());
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL wroff_missing pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_throttle();
        step_t st[$]; exp_t e; bit g;
        bit run1 [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
        bit run2 [9] = '{1, 0, 0, 0, 1, 0, 0, 1, 0};
        sel = 2; idle_cycles(6); sb.delete();
        for (int i = 0; i < 9; i++)
            st.push_back(mk(1, 0, 8'h80, 4'h0, 32'h0, 0, 32'h0, run1[i]));
        for (int i = 0; i < 3; i++) st.push_back(idle());
        for (int i = 0; i < 9; i++)
            st.push_back(mk(1, 0, 8'h80, 4'h0, 32'h0, (i == 3), 32'h0, run2[i]));
        for (int i = 0; i < 3; i++) st.push_back(idle());
        foreach (st[k]) begin
            drive(st[k], g);
            n_cmp++;
            if (g !== st[k].g) begin
                n_err++; $display("FAIL thr_gnt step=%0d gnt=%b expected %b", k, g, st[k].g);
            end else if (g) $display("thr_gnt: step=%0d granted", k);
            @(posedge clk); #1;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (get_vld() !== 1'b1 || get_rdata() !== e.data) begin
                    n_err++; $display("FAIL thr_resp cyc=%0d vld=%b rdata=%h expected vld=1 rdata=%h", cyc, get_vld(), get_rdata(), e.data);
                end
            end else begin
                n_cmp++;
                if (get_vld() !== 1'b0 || get_rdata() !== 32'h0) begin
                    n_err++; $display("FAIL thr_idle cyc=%0d vld=%b rdata=%h expected vld=0 rdata=0", cyc, get_vld(), get_rdata());
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL thr_missing pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_reset_midflight();
        step_t st[$]; exp_t e; bit g;
        sel = 3; idle_cycles(6); sb.delete();
        st.push_back(mk(1, 1, 8'h40, 4'hF, 32'h12345678, 0, 32'h0, 1));
        for (int i = 0; i < 5; i++) st.push_back(idle());
        st.push_back(mk(1, 0, 8'h40, 4'h0, 32'h0, 0, 32'h12345678, 1));
        st.push_back(mk(1, 0, 8'h40, 4'h0, 32'h0, 0, 32'h12345678, 1));
        // Reset is inserted after this step; then expect silence and a cleared word.
        for (int i = 0; i < 6; i++) st.push_back(idle());
        st.push_back(mk(1, 0, 8'h40, 4'h0, 32'h0, 0, 32'h0, 1));
        for (int i = 0; i < 5; i++) st.push_back(idle());
        foreach (st[k]) begin
            if (k == 8) begin
                req = 1'b1; wen = 1'b0; add = 8'h40; rst_n = 1'b0;
                #1;
                sb.delete();
                n_cmp++;
                if ({gnt_d, vld_d, rdata_d} !== 34'h0) begin
                    n_err++; $display("FAIL rst_mid_out gnt=%b vld=%b rdata=%h expected all zero", gnt_d, vld_d, rdata_d);
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
                $display("rst_mid: reset pulse applied at cyc=%0d", cyc);
            end
            drive(st[k], g);
            n_cmp++;
            if (g !== st[k].g) begin
                n_err++; $display("FAIL rst_gnt step=%0d gnt=%b expected %b", k, g, st[k].g);
            end
            @(posedge clk); #1;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front(); n_cmp++;
                if (get_vld() !== 1'b1 || get_rdata() !== e.data) begin
                    n_err++; $display("FAIL rst_resp cyc=%0d vld=%b rdata=%h expected vld=1 rdata=%h", cyc, get_vld(), get_rdata(), e.data);
                end else $display("rst_resp: cyc=%0d rdata=%h", cyc, get_rdata());
            end else begin
                n_cmp++;
                if (get_vld() !== 1'b0 || get_rdata() !== 32'h0) begin
                    n_err++; $display("FAIL rst_idle cyc=%0d vld=%b rdata=%h expected vld=0 rdata=0", cyc, get_vld(), get_rdata());
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL rst_missing pending=%0d expected 0", sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_write_resp_off();
        test_throttle();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
